// File: rtl/fd_pipe_reg_elastic.sv
// Elastic fetch-to-decode pipeline register: valid/ready handshake, one-entry skid
// buffer, synchronous flush with NOP injection and a saturating stall-cycle counter.
module fd_pipe_reg_elastic #(
    parameter int                  INSTR_W   = 16,
    parameter int                  PC_W      = 16,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = 16'h0800,
    parameter int                  CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    inc_pc_in,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    inc_pc_out,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic               main_v_q, main_v_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic               skid_v_q, skid_v_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic accept;
    logic deq;

    // Ready comes only from the skid flag, so there is no combinational path from out_ready.
    assign in_ready = !skid_v_q;
    assign accept   = in_valid && in_ready;
    assign deq      = main_v_q && out_ready;

    always_comb begin
        main_v_d     = main_v_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_v_d     = skid_v_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        stall_cnt_d  = stall_cnt_q;

        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || deq) begin
            if (skid_v_q) begin
                main_v_d     = 1'b1;
                main_instr_d = skid_instr_q;
                main_pc_d    = skid_pc_q;
                skid_v_d     = 1'b0;
            end else if (accept) begin
                main_v_d     = 1'b1;
                main_instr_d = instr_in;
                main_pc_d    = inc_pc_in;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_v_d     = 1'b1;
            skid_instr_d = instr_in;
            skid_pc_d    = inc_pc_in;
        end

        if (main_v_q && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v_q     <= 1'b0;
            main_instr_q <= '0;
            main_pc_q    <= '0;
            skid_v_q     <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_v_q     <= main_v_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_v_q     <= skid_v_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign out_valid  = main_v_q;
    assign instr_out  = main_v_q ? main_instr_q : NOP_INSTR;
    assign inc_pc_out = main_v_q ? main_pc_q : '0;
    assign occupancy  = {1'b0, main_v_q} + {1'b0, skid_v_q};
    assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_fd_pipe_reg_elastic.sv
// Directed and random checks of fd_pipe_reg_elastic against a FIFO scoreboard model.
module tb_fd_pipe_reg_elastic;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr_in;
    logic [15:0] inc_pc_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] instr_out;
    logic [15:0] inc_pc_out;
    logic [1:0]  occupancy;
    logic [3:0]  stall_cnt;

    int checks   = 0;
    int failures = 0;

    beat_t q[$];
    int    cnt_m = 0;

    fd_pipe_reg_elastic #(
        .INSTR_W   (16),
        .PC_W      (16),
        .NOP_INSTR (16'h0800),
        .CNT_W     (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr_in   (instr_in),
        .inc_pc_in  (inc_pc_in),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr_out  (instr_out),
        .inc_pc_out (inc_pc_out),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The skid entry may only be occupied while the main entry is.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            assert (!(dut.skid_v_q && !dut.main_v_q)) else begin
                failures++;
                $error("FAIL invariant observed skid_v=%b main_v=%b expected skid_v->main_v",
                       dut.skid_v_q, dut.main_v_q);
            end
        end
    end

    task automatic check_outputs(input string tag);
        logic        ev;
        logic [15:0] ei;
        logic [15:0] ep;
        ev = (q.size() > 0);
        ei = ev ? q[0].instr : 16'h0800;
        ep = ev ? q[0].pc : 16'h0000;
        chk({tag, ".out_valid"},  {31'b0, out_valid}, {31'b0, ev});
        chk({tag, ".instr_out"},  {16'b0, instr_out}, {16'b0, ei});
        chk({tag, ".inc_pc_out"}, {16'b0, inc_pc_out}, {16'b0, ep});
        chk({tag, ".occupancy"},  {30'b0, occupancy}, 32'(q.size()));
        chk({tag, ".in_ready"},   {31'b0, in_ready}, {31'b0, (q.size() < 2)});
        chk({tag, ".stall_cnt"},  {28'b0, stall_cnt}, 32'(cnt_m));
    endtask

    // Called at a falling edge: drive, check, clock, update model, return at next falling edge.
    task automatic cycle(input string tag, input bit iv, input logic [15:0] ins,
                         input logic [15:0] pc, input bit fl, input bit ordy);
        bit acc;
        bit dq;
        bit stl;
        beat_t b;
        in_valid  = iv;
        instr_in  = ins;
        inc_pc_in = pc;
        flush     = fl;
        out_ready = ordy;
        #1;
        check_outputs(tag);
        acc = iv && (q.size() < 2);
        dq  = (q.size() > 0) && ordy;
        stl = (q.size() > 0) && !ordy && !fl;
        @(posedge clk);
        if (dq) void'(q.pop_front());
        if (fl) q.delete();
        else if (acc) begin
            b.instr = ins;
            b.pc    = pc;
            q.push_back(b);
        end
        if (stl && cnt_m < 15) cnt_m++;
        $display("step %-10s iv=%0b in=%h/%h fl=%0b ordy=%0b acc=%0b deq=%0b occ_model=%0d",
                 tag, iv, ins, pc, fl, ordy, acc, dq, q.size());
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        instr_in  = 16'h0;
        inc_pc_in = 16'h0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset held with random inputs
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            instr_in  = 16'($urandom);
            inc_pc_in = 16'($urandom);
            flush     = 1'($urandom);
            out_ready = 1'($urandom);
            #1;
            check_outputs("reset");
            @(negedge clk);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_rst", 1'b0, 16'h1234, 16'h0002, 1'b0, 1'b1);

        // Streaming at full rate
        cycle("stream", 1'b1, 16'h1111, 16'h0002, 1'b0, 1'b1);
        cycle("stream", 1'b1, 16'h2222, 16'h0004, 1'b0, 1'b1);
        cycle("stream", 1'b1, 16'h3333, 16'h0006, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle("stream", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // Back-pressure fills the skid entry; C is refused until space frees
        cycle("skid", 1'b1, 16'hA000, 16'h0010, 1'b0, 1'b0);
        cycle("skid", 1'b1, 16'hB000, 16'h0012, 1'b0, 1'b0);
        cycle("skid", 1'b1, 16'hC000, 16'h0014, 1'b0, 1'b0);
        chk("skid.occ_full", {30'b0, occupancy}, 32'd2);
        chk("skid.hold_a", {16'b0, instr_out}, 32'h0000A000);
        cycle("skid", 1'b1, 16'hC000, 16'h0014, 1'b0, 1'b1);
        cycle("skid", 1'b1, 16'hC000, 16'h0014, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle("skid", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("skid.stall_cnt", {28'b0, stall_cnt}, 32'd2);

        // Flush with both entries occupied and a beat arriving
        cycle("flush", 1'b1, 16'hE000, 16'h0020, 1'b0, 1'b0);
        cycle("flush", 1'b1, 16'hF000, 16'h0022, 1'b0, 1'b0);
        cycle("flush", 1'b1, 16'hD000, 16'h0024, 1'b1, 1'b0);
        chk("flush.nop", {16'b0, instr_out}, 32'h00000800);
        for (int i = 0; i < 3; i++) cycle("flush", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // Stall counter saturation
        cycle("sat", 1'b1, 16'h5555, 16'h0030, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle("sat", 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("sat.stall_cnt", {28'b0, stall_cnt}, 32'd15);
        cycle("sat", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("sat.hold15", {28'b0, stall_cnt}, 32'd15);

        // Asynchronous reset between edges with the buffer full
        cycle("areset", 1'b1, 16'h7000, 16'h0040, 1'b0, 1'b0);
        cycle("areset", 1'b1, 16'h7100, 16'h0042, 1'b0, 1'b0);
        chk("areset.occ_before", {30'b0, occupancy}, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        cnt_m = 0;
        check_outputs("areset_now");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) cycle("post_arst", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

        // Random traffic against the scoreboard
        for (int i = 0; i < 200; i++) begin
            cycle("random", 1'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 15) == 0), 1'($urandom));
        end
        for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        chk("drain.empty", {30'b0, occupancy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
